// File: rtl/uart_rx_pkg.sv
// Shared definitions for the configurable UART receiver.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package uart_rx_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // True when a receiver parameter set can be built and sampled sensibly.
   function automatic bit rx_params_legal(input int cpb, input int db,
                                          input int pm, input int sb);
      return (cpb >= 3) && (db >= 5) && (db <= 9) &&
             (pm >= PARITY_NONE) && (pm <= PARITY_ODD) &&
             ((sb == 1) || (sb == 2));
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none.
module uart_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Resets to 1 so an idle line never looks like a start bit after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity and stop bits, error flags, good-byte checksum.
// Latency: valid pulses 1 cycle after the last stop sample; checksum updates 1 cycle after valid.
// Backpressure: none; the consumer must take each one-cycle valid pulse.
module uart_rx_cfg
   import uart_rx_pkg::*;
#(
   parameter int cycles_per_bit = 4,
   parameter int data_bits      = 8,
   parameter int parity_mode    = 0,
   parameter int stop_bits      = 1
) (
   input  logic                 clock,
   input  logic                 tock_reset,
   input  logic                 serial,
   output logic [data_bits-1:0] get_data_out_ret,
   output logic                 get_valid_ret,
   output logic                 get_parity_err_ret,
   output logic                 get_frame_err_ret,
   output logic                 get_busy_ret,
   output logic [31:0]          get_checksum_ret
);

   localparam int CW = $clog2(cycles_per_bit);
   localparam logic [CW-1:0] CNT_FULL = CW'(cycles_per_bit - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((cycles_per_bit - 1) / 2);
   localparam logic [3:0]    IDX_LAST = 4'(data_bits - 1);
   localparam logic          STOP_LAST = 1'(stop_bits - 1);

   if (!rx_params_legal(cycles_per_bit, data_bits, parity_mode, stop_bits)) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal parameter combination");
   end

   logic s;

   uart_sync2 u_sync (
      .clk_i (clock),
      .rst_i (tock_reset),
      .d_i   (serial),
      .q_o   (s)
   );

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [data_bits-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [data_bits-1:0] out_data_q, out_data_d;
   logic                 valid_q, valid_d;
   logic                 out_perr_q, out_perr_d;
   logic                 out_ferr_q, out_ferr_d;
   logic [31:0]          csum_q, csum_d;
   logic                 exp_par;

   // Expected parity bit: even parity makes the total ones count even, odd inverts it.
   assign exp_par = (^shift_q) ^ (parity_mode == PARITY_ODD);

   // Frame sequencing: each bit is sampled once, when the phase counter reaches zero.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      out_data_d = out_data_q;
      out_perr_d = out_perr_q;
      out_ferr_d = out_ferr_q;
      valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!s) begin
               cnt_d   = CNT_HALF;
               idx_d   = 4'd0;
               stop_d  = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (s) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = CNT_FULL;
                  idx_d   = 4'd0;
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               // LSB arrives first, so after data_bits shifts bit i sits at index i.
               shift_d = {s, shift_q[data_bits-1:1]};
               cnt_d   = CNT_FULL;
               if (idx_q == IDX_LAST) begin
                  state_d = (parity_mode != PARITY_NONE) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         PARITY: begin
            if (cnt_q == '0) begin
               perr_d  = (s != exp_par);
               cnt_d   = CNT_FULL;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               ferr_d = ferr_q | ~s;
               cnt_d  = CNT_FULL;
               if (stop_q == STOP_LAST) begin
                  state_d    = IDLE;
                  valid_d    = 1'b1;
                  out_data_d = shift_q;
                  out_perr_d = perr_q;
                  out_ferr_d = ferr_q | ~s;
               end else begin
                  stop_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Checksum accumulates only frames that arrived without any error.
   always_comb begin
      csum_d = csum_q;
      if (valid_q && !out_perr_q && !out_ferr_q) begin
         csum_d = csum_q + 32'(out_data_q);
      end
   end

   // State registers; reset aborts any frame in flight without producing output.
   always_ff @(posedge clock) begin
      if (tock_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         out_perr_q <= 1'b0;
         out_ferr_q <= 1'b0;
         csum_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         out_data_q <= out_data_d;
         valid_q    <= valid_d;
         out_perr_q <= out_perr_d;
         out_ferr_q <= out_ferr_d;
         csum_q     <= csum_d;
      end
   end

   assign get_data_out_ret   = out_data_q;
   assign get_valid_ret      = valid_q;
   assign get_parity_err_ret = out_perr_q;
   assign get_frame_err_ret  = out_ferr_q;
   assign get_busy_ret       = (state_q != IDLE);
   assign get_checksum_ret   = csum_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg across four parameter sets sharing one clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_cfg;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       tock_reset;
   logic [3:0] ser;

   logic [7:0]  dat_a, dat_b, dat_c;
   logic [6:0]  dat_d;
   logic        vld_a, vld_b, vld_c, vld_d;
   logic        pe_a, pe_b, pe_c, pe_d;
   logic        fe_a, fe_b, fe_c, fe_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic [31:0] cs_a, cs_b, cs_c, cs_d;

   // A: 8N1 cpb=3   B: 8E1 cpb=3   C: 8N2 cpb=3   D: 7N1 cpb=4
   uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(0), .stop_bits(1)) u_a (
      .clock(clock), .tock_reset(tock_reset), .serial(ser[0]),
      .get_data_out_ret(dat_a), .get_valid_ret(vld_a), .get_parity_err_ret(pe_a),
      .get_frame_err_ret(fe_a), .get_busy_ret(busy_a), .get_checksum_ret(cs_a));
   uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(1), .stop_bits(1)) u_b (
      .clock(clock), .tock_reset(tock_reset), .serial(ser[1]),
      .get_data_out_ret(dat_b), .get_valid_ret(vld_b), .get_parity_err_ret(pe_b),
      .get_frame_err_ret(fe_b), .get_busy_ret(busy_b), .get_checksum_ret(cs_b));
   uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(0), .stop_bits(2)) u_c (
      .clock(clock), .tock_reset(tock_reset), .serial(ser[2]),
      .get_data_out_ret(dat_c), .get_valid_ret(vld_c), .get_parity_err_ret(pe_c),
      .get_frame_err_ret(fe_c), .get_busy_ret(busy_c), .get_checksum_ret(cs_c));
   uart_rx_cfg #(.cycles_per_bit(4), .data_bits(7), .parity_mode(0), .stop_bits(1)) u_d (
      .clock(clock), .tock_reset(tock_reset), .serial(ser[3]),
      .get_data_out_ret(dat_d), .get_valid_ret(vld_d), .get_parity_err_ret(pe_d),
      .get_frame_err_ret(fe_d), .get_busy_ret(busy_d), .get_checksum_ret(cs_d));

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   rec_t q_a[$];
   rec_t q_b[$];
   rec_t q_c[$];
   rec_t q_d[$];

   // Record every valid pulse, sampled on the falling edge.
   always @(negedge clock) begin
      if (vld_a) q_a.push_back({1'b0, dat_a, pe_a, fe_a});
      if (vld_b) q_b.push_back({1'b0, dat_b, pe_b, fe_b});
      if (vld_c) q_c.push_back({1'b0, dat_c, pe_c, fe_c});
      if (vld_d) q_d.push_back({2'b0, dat_d, pe_d, fe_d});
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int inst);
      case (inst)
         0: return q_a.size();
         1: return q_b.size();
         2: return q_c.size();
         default: return q_d.size();
      endcase
   endfunction

   function automatic rec_t qpop(input int inst);
      case (inst)
         0: return q_a.pop_front();
         1: return q_b.pop_front();
         2: return q_c.pop_front();
         default: return q_d.pop_front();
      endcase
   endfunction

   function automatic void qclear(input int inst);
      case (inst)
         0: q_a.delete();
         1: q_b.delete();
         2: q_c.delete();
         default: q_d.delete();
      endcase
   endfunction

   // Wait (bounded) for the next recorded frame and compare it.
   task automatic expect_frame(input int inst, input string tag, input logic [8:0] d,
                               input logic pe, input logic fe);
      rec_t r;
      for (int i = 0; i < 200; i++) begin
         if (qsize(inst) > 0) break;
         @(negedge clock);
      end
      check({tag, "_present"}, 32'(qsize(inst) > 0), 32'd1);
      if (qsize(inst) > 0) begin
         r = qpop(inst);
         check({tag, "_data"}, 32'(r.d), 32'(d));
         check({tag, "_perr"}, 32'(r.pe), 32'(pe));
         check({tag, "_ferr"}, 32'(r.fe), 32'(fe));
      end
   endtask

   task automatic send_raw(input int inst, input logic [15:0] bits, input int len, input int cpb);
      for (int i = 0; i < len; i++) begin
         ser[inst] = bits[i];
         repeat (cpb) @(negedge clock);
      end
   endtask

   // Start bit, data LSB first, optional parity bit, stop bit(s); s2 is the second stop level.
   task automatic send_frame(input int inst, input logic [8:0] d, input int nd, input int np,
                             input logic par, input int ns, input logic s2, input int cpb);
      logic [15:0] bits;
      int pos;
      bits    = '1;
      bits[0] = 1'b0;
      pos     = 1;
      for (int i = 0; i < nd; i++) begin
         bits[pos] = d[i];
         pos++;
      end
      if (np != 0) begin
         bits[pos] = par;
         pos++;
      end
      bits[pos] = 1'b1;
      pos++;
      if (ns == 2) begin
         bits[pos] = s2;
         pos++;
      end
      send_raw(inst, bits, pos, cpb);
   endtask

   string msg;

   initial begin
      msg        = "hello world";
      ser        = 4'hF;
      tock_reset = 1'b1;
      repeat (3) @(negedge clock);
      tock_reset = 1'b0;
      @(negedge clock);

      // Reset state
      check("rst_data",  32'(dat_a),  32'h0);
      check("rst_valid", 32'(vld_a),  32'h0);
      check("rst_perr",  32'(pe_a),   32'h0);
      check("rst_ferr",  32'(fe_a),   32'h0);
      check("rst_busy",  32'(busy_a), 32'h0);
      check("rst_csum",  cs_a,        32'h0);

      // 8N1 two bytes
      send_frame(0, 9'h55, 8, 0, 1'b0, 1, 1'b1, 3);
      send_frame(0, 9'hA3, 8, 0, 1'b0, 1, 1'b1, 3);
      expect_frame(0, "t1_b0", 9'h55, 1'b0, 1'b0);
      expect_frame(0, "t1_b1", 9'hA3, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      check("t1_csum", cs_a, 32'h0000_00F8);

      // Even parity: good then bad parity bit
      send_frame(1, 9'h07, 8, 1, 1'b1, 1, 1'b1, 3);
      expect_frame(1, "t2_good", 9'h07, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      check("t2_csum_good", cs_b, 32'h7);
      send_frame(1, 9'h07, 8, 1, 1'b0, 1, 1'b1, 3);
      expect_frame(1, "t2_bad", 9'h07, 1'b1, 1'b0);
      repeat (4) @(negedge clock);
      check("t2_csum_bad", cs_b, 32'h7);

      // 8N2 with second stop bit low
      send_frame(2, 9'h3C, 8, 0, 1'b0, 2, 1'b0, 3);
      ser[2] = 1'b1;
      expect_frame(2, "t3", 9'h3C, 1'b0, 1'b1);
      repeat (20) @(negedge clock);
      check("t3_csum", cs_c, 32'h0);
      check("t3_no_extra", 32'(qsize(2)), 32'h0);

      // 7-bit receiver: one-cycle glitch then a real frame
      ser[3] = 1'b0;
      @(negedge clock);
      ser[3] = 1'b1;
      repeat (12) @(negedge clock);
      check("t4_glitch_novalid", 32'(qsize(3)), 32'h0);
      check("t4_glitch_busy",    32'(busy_d),   32'h0);
      send_frame(3, 9'h41, 7, 0, 1'b0, 1, 1'b1, 4);
      expect_frame(3, "t4", 9'h41, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      check("t4_csum", cs_d, 32'h41);

      // Reset mid-frame: start + data bits 0..3 of 0x12, then a one-cycle reset
      send_raw(0, 16'h0004, 5, 3);
      check("t5_busy_before", 32'(busy_a), 32'h1);
      tock_reset = 1'b1;
      ser[0]     = 1'b1;
      @(negedge clock);
      tock_reset = 1'b0;
      repeat (40) @(negedge clock);
      check("t5_novalid", 32'(qsize(0)), 32'h0);
      check("t5_data",    32'(dat_a),    32'h0);
      check("t5_csum",    cs_a,          32'h0);
      check("t5_busy",    32'(busy_a),   32'h0);
      check("t5_csum_b",  cs_b,          32'h0);
      send_frame(0, 9'h12, 8, 0, 1'b0, 1, 1'b1, 3);
      expect_frame(0, "t5_after", 9'h12, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      check("t5_csum_after", cs_a, 32'h12);

      // Back-to-back "hello world", then a line break condition
      tock_reset = 1'b1;
      @(negedge clock);
      tock_reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < msg.len(); i++) begin
         send_frame(0, {1'b0, msg[i]}, 8, 0, 1'b0, 1, 1'b1, 3);
      end
      for (int i = 0; i < msg.len(); i++) begin
         expect_frame(0, $sformatf("t6_chr%0d", i), {1'b0, msg[i]}, 1'b0, 1'b0);
      end
      repeat (4) @(negedge clock);
      check("t6_csum", cs_a, 32'h0000_045C);
      ser[0] = 1'b0;
      expect_frame(0, "t6_break0", 9'h00, 1'b0, 1'b1);
      expect_frame(0, "t6_break1", 9'h00, 1'b0, 1'b1);
      check("t6_break_csum", cs_a, 32'h0000_045C);
      ser[0] = 1'b1;
      repeat (40) @(negedge clock);
      qclear(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
